// File: rtl/audio_sample_scheduler.sv
// Byte FIFO between a serial deserializer and a PWM sample stage.
// Releases one byte per sample tick once prefilled, with flow control.
module audio_sample_scheduler #(
  parameter int SAMPLE_DIV  = 3125,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8,
  parameter int HIGH_WATER  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     enable,
  output logic [7:0]               sample,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     cts,
  output logic                     playing,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [7:0] MID = 8'h80;

  typedef enum logic {FILL, PLAY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      mem [DEPTH];

  logic            tick;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [LW-1:0]   level_nx;

  always_comb begin
    tick = (cnt == CW'(SAMPLE_DIV - 1));
    full = (level == LW'(DEPTH));
    pop  = (state == PLAY) && enable && tick
           && (level != '0);
    // a pop in the same cycle frees the slot
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
    level_nx = level;
    unique case ({push, pop})
      2'b10:   level_nx = level + LW'(1);
      2'b01:   level_nx = level - LW'(1);
      default: level_nx = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FILL;
      cnt           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      sample        <= MID;
      sample_strobe <= 1'b0;
      cts           <= 1'b1;
      playing       <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      cnt           <= tick ? '0 : cnt + CW'(1);
      sample_strobe <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop) overrun <= 1'b1;
      level <= level_nx;
      cts   <= (level_nx < LW'(HIGH_WATER));
      unique case (state)
        FILL: begin
          if (enable && level >= LW'(START_LEVEL)) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (!enable) begin
            state         <= FILL;
            playing       <= 1'b0;
            sample        <= MID;
            sample_strobe <= 1'b1;
          end else if (tick) begin
            sample_strobe <= 1'b1;
            if (level == '0) begin
              state    <= FILL;
              playing  <= 1'b0;
              underrun <= 1'b1;
              sample   <= MID;
            end else begin
              sample <= mem[rd_ptr];
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler.
// Small config: SAMPLE_DIV=4, DEPTH=8, START_LEVEL=4, HIGH_WATER=6.
module tb_audio_sample_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       enable;
  logic [7:0] sample;
  logic       sample_strobe;
  logic [3:0] level;
  logic       cts;
  logic       playing;
  logic       underrun;
  logic       overrun;

  audio_sample_scheduler #(
    .SAMPLE_DIV(4), .DEPTH(8),
    .START_LEVEL(4), .HIGH_WATER(6)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .enable(enable), .sample(sample),
    .sample_strobe(sample_strobe), .level(level),
    .cts(cts), .playing(playing),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         tk;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   tb_cnt = 0;
  int   last = 0;

  // independent model of the sample tick phase
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) tb_cnt = 0;
    else tb_cnt = (tb_cnt + 1) % 4;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp = n_cmp + 1;
    if (act != req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic exp_s(input logic [7:0] d, input bit tk,
                       input int gap);
    exp_t e;
    e.d = d; e.tk = tk; e.gap = gap;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sample_strobe) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", sample, 999);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample", sample, e.d);
        if (e.tk) chk("tick_latency", tb_cnt, 0);
        if (e.gap != 0) chk("strobe_gap", cyc - last, e.gap);
      end
      last = cyc;
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_underrun(input int bound);
    for (int k = 0; k < bound && !underrun; k++) step();
    chk("underrun_wait", underrun, 1);
  endtask

  initial begin
    int lv;
    bit found;
    reset = 1'b1; in_valid = 1'b0;
    in_data = 8'h00; enable = 1'b0;
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_sample", sample, 8'h80);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_cts", cts, 1);
    chk("rst_playing", playing, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0; enable = 1'b1;

    // prefill and playback
    push(8'h10); exp_s(8'h10, 1, 0);
    push(8'h20); exp_s(8'h20, 1, 4);
    push(8'h30); exp_s(8'h30, 1, 4);
    chk("pre_level", level, 3);
    chk("pre_playing", playing, 0);
    chk("pre_sample", sample, 8'h80);
    push(8'h40); exp_s(8'h40, 1, 4);
    exp_s(8'h80, 1, 4);
    chk("lvl4_level", level, 4);
    chk("lvl4_playing", playing, 0);
    step();
    chk("play_start", playing, 1);

    // underrun then resume
    wait_underrun(40);
    chk("ur_playing", playing, 0);
    chk("ur_sample", sample, 8'h80);
    chk("ur_level", level, 0);
    for (int i = 1; i <= 4; i++) begin
      push(8'h50 + 8'(i));
      exp_s(8'h50 + 8'(i), 1, (i == 1) ? 0 : 4);
    end
    exp_s(8'h80, 1, 4);
    step();
    chk("resume_playing", playing, 1);
    chk("resume_underrun", underrun, 1);
    for (int k = 0; k < 60 && playing; k++) step();
    chk("ur2_playing", playing, 0);
    chk("ur2_underrun", underrun, 1);
    step();
    chk("drain1", q.size(), 0);

    // overrun and flow control
    reset = 1'b1; step(); reset = 1'b0; enable = 1'b0;
    chk("rst2_underrun", underrun, 0);
    for (int i = 1; i <= 9; i++) begin
      push(8'h60 + 8'(i));
      lv = (i > 8) ? 8 : i;
      chk("ov_level", level, lv);
      chk("ov_cts", cts, (lv < 6) ? 1 : 0);
      chk("ov_flag", overrun, (i == 9) ? 1 : 0);
      if (i <= 8) exp_s(8'h60 + 8'(i), 1, (i == 1) ? 0 : 4);
    end
    exp_s(8'h80, 1, 4);
    enable = 1'b1;
    wait_underrun(100);
    chk("ov_drain_level", level, 0);
    step();
    chk("drain2", q.size(), 0);

    // full FIFO with push and pop on the same tick
    reset = 1'b1; step(); reset = 1'b0; enable = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(8'h70 + 8'(i));
      exp_s(8'h70 + 8'(i), 1, (i == 1) ? 0 : 4);
    end
    chk("full_level", level, 8);
    chk("full_cts", cts, 0);
    chk("full_overrun", overrun, 0);
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (playing && tb_cnt == 3) found = 1'b1;
      else step();
    end
    chk("full_tick_found", found, 1);
    chk("full_pre_level", level, 8);
    push(8'h79); exp_s(8'h79, 1, 4);
    exp_s(8'h80, 1, 4);
    chk("pp_level", level, 8);
    chk("pp_overrun", overrun, 0);
    wait_underrun(100);
    step();
    chk("drain3", q.size(), 0);

    // reset in the middle of playback
    reset = 1'b1; step(); reset = 1'b0; enable = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'h80 + 8'(i));
    exp_s(8'h81, 1, 0);
    enable = 1'b1;
    for (int k = 0; k < 30 && !(playing && level == 5); k++)
      step();
    chk("mid_playing", playing, 1);
    chk("mid_level", level, 5);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hff;
    step();
    reset = 1'b0; in_valid = 1'b0; enable = 1'b0;
    chk("mr_level", level, 0);
    chk("mr_sample", sample, 8'h80);
    chk("mr_playing", playing, 0);
    chk("mr_underrun", underrun, 0);
    chk("mr_overrun", overrun, 0);
    chk("mr_cts", cts, 1);
    for (int k = 0; k < 8; k++) step();
    chk("mr_level_after", level, 0);
    chk("drain4", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
